// File: rtl/decode_pkg.sv
// Shared types and constants for the LZS decoder job scheduler.
package decode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_TMO  = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_ZLEN = 2'b11
    } err_t;

    localparam int CLR_CYCLES = 2;

endpackage

// File: rtl/decode_sched_if.sv
// Channel request, decoder control and result bundle of the job scheduler.
interface decode_sched_if #(
    parameter int NCH = 4,
    parameter int LW  = 16
);
    logic [NCH-1:0]    req;
    logic [NCH*LW-1:0] req_len;
    logic [NCH-1:0]    grant;
    logic              dec_clr;
    logic              in_load;
    logic [LW-1:0]     in_len;
    logic              dec_valid;
    logic              dec_done;
    logic              res_valid;
    logic              res_ack;
    logic [2:0]        res_ch;
    logic [LW-1:0]     res_cnt;
    logic [1:0]        res_err;

    modport slave (
        input  req, req_len, dec_valid, dec_done, res_ack,
        output grant, dec_clr, in_load, in_len, res_valid, res_ch, res_cnt, res_err
    );

    modport master (
        output req, req_len, dec_valid, dec_done, res_ack,
        input  grant, dec_clr, in_load, in_len, res_valid, res_ch, res_cnt, res_err
    );
endinterface

// File: rtl/decode_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(ptr_i) + k) % NCH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/decode_sched.sv
// Grants the shared LZS decoder to one channel at a time and reports a per-job result.
//  state   | meaning
//  IDLE    | waiting for any request, arbitrate
//  CLR     | decoder/history clear, CLR_CYCLES cycles
//  LOAD    | one-cycle in_load of the granted length
//  RUN     | count decoded bytes, watchdog armed
//  RESP    | result held until res_ack
module decode_sched
    import decode_pkg::*;
#(
    parameter int NCH = 4,
    parameter int LW  = 16,
    parameter int TMO = 1024
) (
    input  logic          clk,
    input  logic          rst,
    decode_sched_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW = $clog2(TMO + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [LW-1:0] CNT_MAX = '1;

    state_t         state_q, state_d;
    logic [NCH-1:0] grant_q, grant_d;
    logic           dec_clr_q, dec_clr_d;
    logic           in_load_q, in_load_d;
    logic           res_valid_q, res_valid_d;
    logic [LW-1:0]  in_len_q, in_len_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [2:0]     res_ch_q, res_ch_d;
    err_t           err_q, err_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic [CW-1:0]  clr_q, clr_d;

    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic [LW-1:0]  sel_len;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign sel_len = bus.req_len[int'(arb_idx)*LW +: LW];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        dec_clr_d   = dec_clr_q;
        in_load_d   = 1'b0;
        res_valid_d = res_valid_q;
        in_len_d    = in_len_q;
        cnt_d       = cnt_q;
        res_ch_d    = res_ch_q;
        err_d       = err_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        clr_d       = clr_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d  = arb_gnt;
                    in_len_d = sel_len;
                    res_ch_d = 3'(arb_idx);
                    ptr_d    = arb_idx;
                    cnt_d    = '0;
                    if (sel_len == '0) begin
                        state_d     = ST_RESP;
                        err_d       = ERR_ZLEN;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_CLR;
                        err_d     = ERR_OK;
                        dec_clr_d = 1'b1;
                        clr_d     = CW'(CLR_CYCLES - 1);
                    end
                end
            end
            ST_CLR: begin
                cnt_d = '0;
                if (clr_q == '0) begin
                    state_d   = ST_LOAD;
                    dec_clr_d = 1'b0;
                    in_load_d = 1'b1;
                end else begin
                    clr_d = clr_q - 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                wd_d    = WW'(TMO - 1);
            end
            ST_RUN: begin
                // Watchdog fires on the TMO-th edge after the last dec_valid (or LOAD).
                if (bus.dec_valid && cnt_q == CNT_MAX) begin
                    state_d     = ST_RESP;
                    err_d       = ERR_OVF;
                    res_valid_d = 1'b1;
                end else begin
                    if (bus.dec_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        wd_d  = WW'(TMO - 1);
                    end else begin
                        wd_d = wd_q - 1'b1;
                    end
                    if (bus.dec_done) begin
                        state_d     = ST_RESP;
                        err_d       = ERR_OK;
                        res_valid_d = 1'b1;
                    end else if (!bus.dec_valid && wd_q <= WW'(1)) begin
                        state_d     = ST_RESP;
                        err_d       = ERR_TMO;
                        res_valid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (bus.res_ack) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    grant_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            dec_clr_q   <= 1'b0;
            in_load_q   <= 1'b0;
            res_valid_q <= 1'b0;
            in_len_q    <= '0;
            cnt_q       <= '0;
            res_ch_q    <= '0;
            err_q       <= ERR_OK;
            ptr_q       <= IW'(NCH - 1);
            wd_q        <= '0;
            clr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            dec_clr_q   <= dec_clr_d;
            in_load_q   <= in_load_d;
            res_valid_q <= res_valid_d;
            in_len_q    <= in_len_d;
            cnt_q       <= cnt_d;
            res_ch_q    <= res_ch_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            clr_q       <= clr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.dec_clr   = dec_clr_q;
    assign bus.in_load   = in_load_q;
    assign bus.in_len    = in_len_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_cnt   = cnt_q;
    assign bus.res_err   = err_q;
endmodule

// File: doc/decode_sched.md
# decode_sched

Job scheduler for the LZS decompression engine. Shares one decoder datapath (bit-stream extractor + decode control + history RAM) among NCH requesting channels. Grants the decoder to one channel at a time, round-robin. For each job it pulses a decoder clear, loads the compressed length into the stream source, and counts decoded bytes. Jobs end on the decoder's end-marker indication or a stall watchdog; the block then returns a per-job result.

## Interface
Parameters:
- NCH, 4, number of requesting channels (2..8)
- LW, 16, width of byte lengths/counts
- TMO, 1024, watchdog: max idle cycles (no out_valid) before abort

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req  in  NCH  per-channel job request, level
- req_len  in  NCH*LW  compressed byte length per channel; channel i at [i*LW +: LW]
- grant  out  NCH  one-hot owner of the decoder, held for the whole job
- dec_clr  out  1  decoder/history clear, high 2 cycles per job
- in_load  out  1  one-cycle pulse loading in_len into the stream source
- in_len  out  LW  granted channel's req_len, registered at grant
- dec_valid  in  1  decoder out_valid (one byte produced)
- dec_done  in  1  decoder out_done (end marker reached)
- res_valid  out  1  result available, held until res_ack
- res_ack  in  1  result consumed
- res_ch  out  3  channel index of result
- res_cnt  out  LW  decoded byte count
- res_err  out  2  00 ok, 01 timeout, 10 count overflow, 11 zero length

## Operation
States: IDLE, CLR, LOAD, RUN, RESP.
- IDLE: if any req, the arbiter picks the first requesting channel after the last-granted pointer (wrapping). grant, in_len and res_ch register; pointer updates. Next state is CLR, or RESP with err 11 if the selected req_len is 0 (the decoder is not touched).
- CLR: dec_clr=1 for 2 cycles. Byte counter and watchdog clear.
- LOAD: in_load=1 for 1 cycle, then RUN.
- RUN: each dec_valid increments res_cnt. The watchdog counts cycles without dec_valid and resets on dec_valid.
  - dec_done -> RESP, err 00.
  - Watchdog reaching TMO -> RESP, err 01.
  - A dec_valid that would wrap res_cnt past all-ones -> res_cnt saturates, RESP, err 10.
- RESP: res_valid=1 and grant held. On res_ack -> IDLE, grant cleared the next cycle.
- Dropping req after grant has no effect; the job runs to completion. A channel is only reconsidered in IDLE.
- Reset values: state IDLE, grant 0, dec_clr 0, in_load 0, in_len 0, res_valid 0, res_ch 0, res_cnt 0, res_err 0. Pointer = NCH-1, so channel 0 has priority after reset.

## Timing
- All outputs are registered.
- req seen in IDLE at cycle t: grant and dec_clr high at t+1 and t+2; in_load at t+3; RUN from t+4.
- dec_valid is counted in the cycle it is high, including in the cycle dec_done rises.
- If dec_done and a watchdog expiry occur in the same cycle, dec_done wins (err 00). If dec_done and overflow coincide, overflow wins (err 10).
- dec_done / expiry at cycle u: res_valid high at u+1. res_cnt and res_err are stable while res_valid is high.
- res_ack is sampled only while res_valid is high. On ack at cycle v: res_valid low at v+1, state IDLE at v+1, next grant earliest v+2.
- dec_valid and dec_done are ignored outside RUN.
- rst mid-job: immediate return to reset values, no result emitted. The decoder is cleared by the next job's CLR.

## Structure
- Package decode_pkg:
  - state encoding (3 bits)
  - res_err codes (ERR_OK, ERR_TMO, ERR_OVF, ERR_ZLEN)
  - CLR_CYCLES = 2
- Sub-module rr_arbiter (NCH, req, pointer, one-hot grant, granted index): purely combinational priority-rotate. The pointer register stays in decode_sched.
- Watchdog width is clog2(TMO+1).

## Test plan
- Single job: req=0001, req_len=0x40, 100 dec_valid pulses, then dec_done -> grant=0001 from t+1, in_load at t+3, res_valid with res_ch=0, res_cnt=100, res_err=00.
- Round robin: req=1111 held, each job acked immediately -> grant order 0001, 0010, 0100, 1000, 0001. No channel is granted twice in a row while others request.
- Watchdog: TMO=16, one dec_valid then silence -> res_err=01 and res_cnt=1 exactly 16 cycles after the last dec_valid. A dec_done arriving in the same cycle as expiry gives err 00.
- Overflow: LW=4, 16 dec_valid pulses -> res_cnt=15 and res_err=10 on the 16th pulse.
- Zero length: req_len=0 -> no dec_clr/in_load, res_valid at t+1, res_err=11. Hold res_ack low for 5 cycles -> grant and res fields stay stable.
- Reset mid-RUN: rst for 1 cycle after 10 bytes -> all outputs 0 the next cycle, no res_valid. A subsequent req=0100 gets a fresh job with res_cnt counted from 0.
